cv32e40x_bch_predict_ctrl: RTL and testbench

//  Dynamic conditional-branch prediction controller for the ID-stage pc_target datapath.
//  - Holds a branch history table (BHT) of 2-bit saturating counters, indexed by PC.
//  - Gives an ID-stage taken/not-taken prediction for each conditional branch.
//  - Trains the table from EX-stage branch resolution.
//  - Sequences a table-initialisation sweep after reset or flush; uses static BTFN prediction meanwhile.
//  - Flags mispredicts and keeps saturating performance counters.

---
 rtl/cv32e40x_bch_predict_ctrl.sv | 159 +++++++++++++++
 tb/tb_cv32e40x_bch_predict_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_bch_predict_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cv32e40x_bch_predict_ctrl
//  Purpose  : Dynamic conditional-branch prediction controller for the ID-stage
//             pc_target datapath. Holds a table of 2-bit saturating counters
//             indexed by PC, predicts in ID, trains from EX resolution, runs a
//             table-initialisation sweep after reset/flush (static BTFN
//             prediction meanwhile), flags mispredicts and keeps saturating
//             performance counters.
//  Ports    : clk, rst (sync, active-high), flush_i
//             ID : id_bch_valid_i, pc_id_i, bch_target_i -> pred_taken_o,
//                  pred_dynamic_o
//             EX : ex_resolve_i, ex_pc_i, ex_taken_i, ex_pred_taken_i
//                  -> mispredict_o
//             init_busy_o, perf_clr_i, bch_cnt_o, mispred_cnt_o
//  Revision : 1.0 - initial release
// ============================================================================
module cv32e40x_bch_predict_ctrl #(
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CNT_INIT    = 2'b01,
    parameter int         PERF_W      = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              flush_i,
    input  wire logic              id_bch_valid_i,
    input  wire logic [31:0]       pc_id_i,
    input  wire logic [31:0]       bch_target_i,
    output logic                   pred_taken_o,
    output logic                   pred_dynamic_o,
    input  wire logic              ex_resolve_i,
    input  wire logic [31:0]       ex_pc_i,
    input  wire logic              ex_taken_i,
    input  wire logic              ex_pred_taken_i,
    output logic                   mispredict_o,
    output logic                   init_busy_o,
    input  wire logic              perf_clr_i,
    output logic [PERF_W-1:0]      bch_cnt_o,
    output logic [PERF_W-1:0]      mispred_cnt_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    localparam logic [IDX_W-1:0]  c_IDX_LAST = IDX_W'(BHT_ENTRIES - 1);
    localparam logic [PERF_W-1:0] c_PERF_MAX = '1;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_init_idx;
    logic [1:0]       r_bht [BHT_ENTRIES];

    logic [IDX_W-1:0] w_idx_id;
    logic [IDX_W-1:0] w_idx_ex;
    logic [1:0]       w_cnt_ex;
    logic [1:0]       w_cnt_next;
    logic             w_run;

    // Bit 0 of the PC is skipped so compressed (2-byte aligned) branches
    // still spread across the table; upper bits alias by design.
    assign w_idx_id = pc_id_i[IDX_W:1];
    assign w_idx_ex = ex_pc_i[IDX_W:1];

    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{pc_id_i[31:IDX_W+1], pc_id_i[0],
                                ex_pc_i[31:IDX_W+1], ex_pc_i[0]};

    assign w_run       = (r_state == c_ST_RUN);
    assign init_busy_o = ~w_run;

    // ------------------------------------------------------------------------
    // Sweep / run state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_INIT;
            r_init_idx <= '0;
        end else begin
            case (r_state)
                c_ST_INIT: begin
                    if (flush_i) begin
                        r_init_idx <= '0;
                    end else if (r_init_idx == c_IDX_LAST) begin
                        r_state    <= c_ST_RUN;
                        r_init_idx <= '0;
                    end else begin
                        r_init_idx <= r_init_idx + IDX_W'(1);
                    end
                end
                default: begin
                    if (flush_i) begin
                        r_state    <= c_ST_INIT;
                        r_init_idx <= '0;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Counter table. No reset: contents are only read after a full sweep.
    // ------------------------------------------------------------------------
    always_comb begin
        w_cnt_ex   = r_bht[w_idx_ex];
        w_cnt_next = w_cnt_ex;
        if (ex_taken_i) begin
            if (w_cnt_ex != 2'b11) w_cnt_next = w_cnt_ex + 2'b01;
        end else begin
            if (w_cnt_ex != 2'b00) w_cnt_next = w_cnt_ex - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_run && !flush_i) begin
                r_bht[r_init_idx] <= CNT_INIT;
            end else if (w_run && ex_resolve_i) begin
                r_bht[w_idx_ex] <= w_cnt_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // ID-stage prediction (read-before-write: no bypass from EX)
    // ------------------------------------------------------------------------
    always_comb begin
        pred_taken_o   = 1'b0;
        pred_dynamic_o = 1'b0;
        if (id_bch_valid_i) begin
            if (w_run) begin
                pred_taken_o   = r_bht[w_idx_id][1];
                pred_dynamic_o = 1'b1;
            end else begin
                // Backward-taken / forward-not-taken while the table is invalid
                pred_taken_o   = (bch_target_i < pc_id_i);
            end
        end
    end

    assign mispredict_o = ex_resolve_i & (ex_taken_i != ex_pred_taken_i);

    // ------------------------------------------------------------------------
    // Saturating performance counters (unaffected by flush)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || perf_clr_i) begin
            bch_cnt_o     <= '0;
            mispred_cnt_o <= '0;
        end else begin
            if (ex_resolve_i && (bch_cnt_o != c_PERF_MAX))
                bch_cnt_o <= bch_cnt_o + PERF_W'(1);
            if (mispredict_o && (mispred_cnt_o != c_PERF_MAX))
                mispred_cnt_o <= mispred_cnt_o + PERF_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40x_bch_predict_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cv32e40x_bch_predict_ctrl
//  Purpose  : Self-checking bench: an abstract table/sweep model compared
//             every cycle, plus directed vectors with literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40x_bch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        id_bch_valid_i = 1'b0;
    logic [31:0] pc_id_i = '0;
    logic [31:0] bch_target_i = '0;
    logic        ex_resolve_i = 1'b0;
    logic [31:0] ex_pc_i = '0;
    logic        ex_taken_i = 1'b0;
    logic        ex_pred_taken_i = 1'b0;
    logic        perf_clr_i = 1'b0;
    logic        pred_taken_o, pred_dynamic_o, mispredict_o, init_busy_o;
    logic [15:0] bch_cnt_o, mispred_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cv32e40x_bch_predict_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .id_bch_valid_i  (id_bch_valid_i),
        .pc_id_i         (pc_id_i),
        .bch_target_i    (bch_target_i),
        .pred_taken_o    (pred_taken_o),
        .pred_dynamic_o  (pred_dynamic_o),
        .ex_resolve_i    (ex_resolve_i),
        .ex_pc_i         (ex_pc_i),
        .ex_taken_i      (ex_taken_i),
        .ex_pred_taken_i (ex_pred_taken_i),
        .mispredict_o    (mispredict_o),
        .init_busy_o     (init_busy_o),
        .perf_clr_i      (perf_clr_i),
        .bch_cnt_o       (bch_cnt_o),
        .mispred_cnt_o   (mispred_cnt_o)
    );

    // ---------------- abstract model ----------------
    // sweep_left: cycles of sweep still to run; the table becomes all CNT_INIT
    // the moment it reaches zero.
    int  sweep_left = 64;
    int  mbht [64];
    int  m_bch = 0;
    int  m_mis = 0;
    bit  model_ok = 1'b0;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 1) % 64);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_ok    = 1'b1;
            sweep_left  = 64;
            m_bch       = 0;
            m_mis       = 0;
        end else begin
            if (perf_clr_i) begin
                m_bch = 0;
                m_mis = 0;
            end else begin
                if (ex_resolve_i && m_bch < 65535) m_bch++;
                if (ex_resolve_i && (ex_taken_i != ex_pred_taken_i) && m_mis < 65535) m_mis++;
            end
            if (sweep_left > 0) begin
                if (flush_i) sweep_left = 64;
                else begin
                    sweep_left--;
                    if (sweep_left == 0) foreach (mbht[i]) mbht[i] = 1;
                end
            end else begin
                if (ex_resolve_i) begin
                    int k;
                    k = idx_of(ex_pc_i);
                    if (ex_taken_i) mbht[k] = (mbht[k] == 3) ? 3 : mbht[k] + 1;
                    else            mbht[k] = (mbht[k] == 0) ? 0 : mbht[k] - 1;
                end
                if (flush_i) sweep_left = 64;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (model_ok) begin
            logic busy, ept, edy, emp;
            busy = (sweep_left > 0);
            ept  = 1'b0;
            edy  = 1'b0;
            if (id_bch_valid_i) begin
                if (busy) ept = (bch_target_i < pc_id_i);
                else begin
                    ept = (mbht[idx_of(pc_id_i)] >= 2);
                    edy = 1'b1;
                end
            end
            emp = ex_resolve_i && (ex_taken_i != ex_pred_taken_i);
            chk("model init_busy", {31'd0, init_busy_o}, {31'd0, busy});
            chk("model pred_taken", {31'd0, pred_taken_o}, {31'd0, ept});
            chk("model pred_dynamic", {31'd0, pred_dynamic_o}, {31'd0, edy});
            chk("model mispredict", {31'd0, mispredict_o}, {31'd0, emp});
            chk("model bch_cnt", {16'd0, bch_cnt_o}, 32'(m_bch));
            chk("model mispred_cnt", {16'd0, mispred_cnt_o}, 32'(m_mis));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input int n);
        ex_pc_i = pc; ex_taken_i = taken; ex_pred_taken_i = taken;
        ex_resolve_i = 1'b1;
        repeat (n) tick();
        ex_resolve_i = 1'b0;
    endtask

    task automatic predict(input logic [31:0] pc, input string name, input logic exp);
        id_bch_valid_i = 1'b1; pc_id_i = pc; bch_target_i = pc + 32'h40;
        settle();
        chk(name, {31'd0, pred_taken_o}, {31'd0, exp});
    endtask

    // Counts cycles with init_busy_o high, bounded
    task automatic count_busy(input string name, input int exp);
        int n;
        n = 0;
        while (init_busy_o && n < 200) begin
            n++;
            tick();
        end
        chk(name, 32'(n), 32'(exp));
    endtask

    initial begin
        int n;
        // 1. reset and sweep
        tick(); tick();
        settle();
        chk("reset busy", {31'd0, init_busy_o}, 32'd1);
        chk("reset bch_cnt", {16'd0, bch_cnt_o}, 32'd0);
        chk("reset mispred_cnt", {16'd0, mispred_cnt_o}, 32'd0);
        chk("reset pred_taken", {31'd0, pred_taken_o}, 32'd0);
        rst = 1'b0;
        id_bch_valid_i = 1'b1; pc_id_i = 32'h100; bch_target_i = 32'h0F0;
        n = 0;
        while (init_busy_o && n < 200) begin
            if (n == 10) begin
                chk("btfn backward taken", {31'd0, pred_taken_o}, 32'd1);
                chk("btfn static", {31'd0, pred_dynamic_o}, 32'd0);
                bch_target_i = 32'h110;
                settle();
                chk("btfn forward not taken", {31'd0, pred_taken_o}, 32'd0);
                bch_target_i = 32'h0F0;
            end
            n++;
            tick();
        end
        chk("sweep length", 32'(n), 32'd64);

        // 2. training on 0x200 (idx 0)
        predict(32'h200, "after init weak nt", 1'b0);
        chk("after init dynamic", {31'd0, pred_dynamic_o}, 32'd1);
        resolve(32'h200, 1'b1, 1);
        predict(32'h200, "one taken", 1'b1);
        resolve(32'h200, 1'b1, 3);
        resolve(32'h200, 1'b0, 1);
        predict(32'h200, "saturated then nt", 1'b1);

        // 3. floor on a fresh entry (0x302 -> idx 1; 0x300 aliases idx 0)
        resolve(32'h302, 1'b0, 4);
        predict(32'h302, "floor", 1'b0);
        resolve(32'h302, 1'b1, 1);
        predict(32'h302, "floor+1", 1'b0);
        resolve(32'h302, 1'b1, 1);
        predict(32'h302, "floor+2", 1'b1);

        // 4. aliasing 0x200 / 0x280 (idx 0, counter currently 2)
        predict(32'h280, "alias sees 0x200", 1'b1);
        resolve(32'h280, 1'b0, 1);
        predict(32'h200, "alias trained down", 1'b0);
        id_bch_valid_i = 1'b1; pc_id_i = 32'h200;
        ex_pc_i = 32'h200; ex_taken_i = 1'b1; ex_pred_taken_i = 1'b0; ex_resolve_i = 1'b1;
        settle();
        chk("same-cycle old value", {31'd0, pred_taken_o}, 32'd0);
        tick();
        ex_resolve_i = 1'b0;
        settle();
        chk("written next cycle", {31'd0, pred_taken_o}, 32'd1);

        // 5. mispredict and counter saturation
        ex_resolve_i = 1'b1; ex_pc_i = 32'h204; ex_taken_i = 1'b1; ex_pred_taken_i = 1'b0;
        settle();
        chk("mispredict set", {31'd0, mispredict_o}, 32'd1);
        ex_pred_taken_i = 1'b1;
        settle();
        chk("mispredict clear", {31'd0, mispredict_o}, 32'd0);
        ex_resolve_i = 1'b0; ex_taken_i = 1'b0;
        settle();
        chk("mispredict idle", {31'd0, mispredict_o}, 32'd0);
        ex_pred_taken_i = 1'b0;
        perf_clr_i = 1'b1;
        tick();
        perf_clr_i = 1'b0;
        ex_resolve_i = 1'b1; ex_taken_i = 1'b1;
        repeat (65540) tick();
        chk("bch_cnt saturated", {16'd0, bch_cnt_o}, 32'h0000FFFF);
        chk("mispred_cnt saturated", {16'd0, mispred_cnt_o}, 32'h0000FFFF);
        perf_clr_i = 1'b1;
        tick();
        perf_clr_i = 1'b0; ex_resolve_i = 1'b0; ex_taken_i = 1'b0;
        settle();
        chk("clear beats increment", {16'd0, bch_cnt_o}, 32'd0);
        chk("clear mispred", {16'd0, mispred_cnt_o}, 32'd0);

        // 6. flush, restart at cycle 30, EX update during sweep, reset mid-RUN
        resolve(32'h304, 1'b1, 2);
        id_bch_valid_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (10) tick();
        resolve(32'h302, 1'b1, 3);
        repeat (17) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        count_busy("flush restart length", 64);
        chk("flush keeps bch_cnt", {16'd0, bch_cnt_o}, 32'd5);
        predict(32'h302, "ex during init dropped", 1'b0);
        predict(32'h304, "re-swept entry", 1'b0);
        id_bch_valid_i = 1'b0;
        resolve(32'h200, 1'b1, 2);
        rst = 1'b1;
        tick();
        settle();
        chk("mid-run reset busy", {31'd0, init_busy_o}, 32'd1);
        chk("mid-run reset cnt", {16'd0, bch_cnt_o}, 32'd0);
        rst = 1'b0;
        count_busy("post-reset sweep", 64);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
